// File: rtl/div32_multicycle_pkg.sv
// Shared constants, state encoding and the inverter/adder helpers for the
// multicycle divider.
package div32_multicycle_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] ZERO_W  = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] MIN_INT = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  function automatic logic [DIV_WIDTH-1:0] inv32(input logic [DIV_WIDTH-1:0] x);
    return ~x;
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [DIV_WIDTH:0] add32(input logic [DIV_WIDTH-1:0] a,
                                               input logic [DIV_WIDTH-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{DIV_WIDTH{1'b0}}, cin};
  endfunction

  function automatic logic [DIV_WIDTH-1:0] neg32(input logic [DIV_WIDTH-1:0] x);
    logic [DIV_WIDTH:0] s;
    s = add32(inv32(x), ZERO_W, 1'b1);
    return s[DIV_WIDTH-1:0];
  endfunction

  function automatic logic [DIV_WIDTH-1:0] abs32(input logic [DIV_WIDTH-1:0] x);
    logic [DIV_WIDTH-1:0] r;
    if (x[DIV_WIDTH-1]) begin
      r = neg32(x);
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/div32_multicycle_div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem, quo} left,
// subtract the divisor by complement-plus-one, keep the result if non-negative.
module div_step
  import div32_multicycle_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic             ge_s;

  // Carry out of rem + ~div + 1 means rem >= div; rem's dropped MSB also counts.
  always_comb begin
    rem_sh_s = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
    trial_s  = add32(rem_sh_s, inv32(div_i), 1'b1);
    ge_s     = trial_s[WIDTH] | rem_i[WIDTH-1];
    if (ge_s) begin
      rem_o = trial_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh_s;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div32_multicycle.sv
// Multicycle signed restoring divider, one quotient bit per clock.
// Optional DIV_REMAINDER_EN adds data_remainder and flags MIN_INT / -1 overflow.
module div32_multicycle
  import div32_multicycle_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] step_rem_s, step_quo_s;
`ifdef DIV_REMAINDER_EN
  logic             sign_a_q, sign_a_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] remout_q, remout_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (divisor_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Next-state logic; a start pulse in any state (re)starts the division.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    sign_d    = sign_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    busy_d    = busy_q;
`ifdef DIV_REMAINDER_EN
    sign_a_d  = sign_a_q;
    ovf_d     = ovf_q;
    remout_d  = remout_q;
`endif
    if (ctrl_div) begin
      rem_d     = ZERO_W;
      quo_d     = abs32(data_operandA);
      divisor_d = abs32(data_operandB);
      sign_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      cnt_d     = {CNT_W{1'b0}};
      busy_d    = 1'b1;
      result_d  = ZERO_W;
      exc_d     = 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_a_d  = data_operandA[WIDTH-1];
      ovf_d     = (data_operandA == MIN_INT) && (data_operandB == {WIDTH{1'b1}});
      remout_d  = ZERO_W;
`endif
      if (data_operandB == ZERO_W) begin
        exc_d   = 1'b1;
        rdy_d   = 1'b1;
        state_d = ST_DONE;
      end else begin
        state_d = ST_ITER;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
        end
        ST_ITER: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_ITER;
          end
        end
        ST_FIX: begin
          if (sign_q) begin
            result_d = neg32(quo_q);
          end else begin
            result_d = quo_q;
          end
`ifdef DIV_REMAINDER_EN
          exc_d = ovf_q;
          if (sign_a_q) begin
            remout_d = neg32(rem_q);
          end else begin
            remout_d = rem_q;
          end
`else
          exc_d = 1'b0;
`endif
          rdy_d   = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= ZERO_W;
      quo_q     <= ZERO_W;
      divisor_q <= ZERO_W;
      sign_q    <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      result_q  <= ZERO_W;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_a_q  <= 1'b0;
      ovf_q     <= 1'b0;
      remout_q  <= ZERO_W;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      sign_q    <= sign_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
`ifdef DIV_REMAINDER_EN
      sign_a_q  <= sign_a_d;
      ovf_q     <= ovf_d;
      remout_q  <= remout_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
`ifdef DIV_REMAINDER_EN
  assign data_remainder = remout_q;
`endif

endmodule

// File: tb/tb_div32_multicycle.sv
// Directed scoreboard bench for div32_multicycle (honours DIV_REMAINDER_EN).
module tb_div32_multicycle;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   rdy_count = 0;

  div32_multicycle dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (data_resultRDY === 1'b1) rdy_count <= rdy_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    exp_t e;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      e.res = 32'd0; e.exc = 1'b1; e.rem = 32'd0;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000; e.rem = 32'd0;
`ifdef DIV_REMAINDER_EN
      e.exc = 1'b1;
`else
      e.exc = 1'b0;
`endif
    end else begin
      e.res = sx / sy; e.rem = sx % sy; e.exc = 1'b0;
    end
    return e;
  endfunction

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input int exp_lat);
    exp_t e;
    int   lat;
    @(negedge clock);
    op_a = x; op_b = y; ctrl_div = 1'b1;
    sb_q.push_back(model(x, y));
    @(negedge clock);
    ctrl_div = 1'b0;
    lat = 1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (data_resultRDY !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    e = sb_q.pop_front();
    check({tag, "_res"}, data_result, e.res);
    check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
`ifdef DIV_REMAINDER_EN
    check({tag, "_rem"}, data_remainder, e.rem);
`endif
    @(negedge clock);
    check({tag, "_rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
    check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt0;
    repeat (3) @(negedge clock);
    check("rst_res", data_result, 32'd0);
    check("rst_exc", {31'd0, data_exception}, 32'd0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    do_op("p100_7", 32'd100, 32'd7, 34);
    do_op("m100_7", -32'sd100, 32'd7, 34);
    do_op("p100_m7", 32'd100, -32'sd7, 34);
    do_op("m7_2", -32'sd7, 32'd2, 34);
    do_op("z_5", 32'd0, 32'd5, 34);
    do_op("min_1", 32'h8000_0000, 32'd1, 34);
    do_op("div0", 32'd5, 32'd0, 1);
    do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 34);
    do_op("big", 32'h7FFF_FFFF, 32'h8000_0000, 34);

    // Abort an in-flight 100/7 ten cycles in with 9/3.
    cnt0 = rdy_count;
    @(negedge clock);
    op_a = 32'd100; op_b = 32'd7; ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (8) @(negedge clock);
    do_op("restart", 32'd9, 32'd3, 34);
    check("restart_pulses", rdy_count - cnt0, 32'd1);

    // Reset in the middle of an operation.
    cnt0 = rdy_count;
    @(negedge clock);
    op_a = 32'd100; op_b = 32'd7; ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (13) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("midrst_res", data_result, 32'd0);
    check("midrst_exc", {31'd0, data_exception}, 32'd0);
    check("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clock);
    check("midrst_pulses", rdy_count - cnt0, 32'd0);
    do_op("post_rst", 32'd81, 32'd9, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
